// File: rtl/if_stage.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | Module      : if_stage                                           |
// | Description : MIPS instruction-fetch stage. Holds the PC, drives |
// |               the instruction-memory address, registers fetched  |
// |               words into IF/ID, handles stall/redirect/flush and |
// |               counts instructions loaded into IF/ID.             |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] current_inst,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [31:0] fetch_count
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;

  // Instruction memory is addressed straight from the PC register.
  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;

  // PC and IF/ID register: redirect flushes the wrong-path word and wins
  // over stall; the low two target bits are masked to keep word alignment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc           <= RESET_PC;
      current_inst <= NOP_INST;
      if_id_pc4    <= 32'h0000_0000;
      if_id_valid  <= 1'b0;
    end else if (redirect) begin
      pc           <= redirect_pc & 32'hFFFF_FFFC;
      current_inst <= NOP_INST;
      if_id_pc4    <= 32'h0000_0000;
      if_id_valid  <= 1'b0;
    end else if (!stall) begin
      pc           <= pc_plus4;
      current_inst <= imem_rdata;
      if_id_pc4    <= pc_plus4;
      if_id_valid  <= 1'b1;
    end
  end

  // Retired-fetch counter: advances only when a real word enters IF/ID.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count <= 32'h0000_0000;
    end else if (!redirect && !stall) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | Module      : tb_if_stage                                        |
// | Description : Directed bench for if_stage with a reference model |
// |               feeding an expected-result queue. Two instances:   |
// |               RESET_PC=0 and RESET_PC=FFFF_FFF8 (wrap case).     |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module tb_if_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        v;
    logic [31:0] fc;
  } st_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  logic [31:0] addr0, rdata0, inst0, pc4_0, fc0;
  logic        v0;
  logic [31:0] addr1, rdata1, inst1, pc4_1, fc1;
  logic        v1;

  int checks = 0;
  int errors = 0;

  st_t m [2];
  st_t sb [$];

  always #5 clk = ~clk;

  // Address-tagged instruction memory for both instances.
  assign rdata0 = 32'hA000_0000 | addr0;
  assign rdata1 = 32'hA000_0000 | addr1;

  if_stage #(.RESET_PC(32'h0000_0000), .NOP_INST(32'h0000_0000)) dut0 (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_addr(addr0), .imem_rdata(rdata0),
    .current_inst(inst0), .if_id_pc4(pc4_0), .if_id_valid(v0),
    .fetch_count(fc0)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFF8), .NOP_INST(32'h0000_0000)) dut1 (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_addr(addr1), .imem_rdata(rdata1),
    .current_inst(inst1), .if_id_pc4(pc4_1), .if_id_valid(v1),
    .fetch_count(fc1)
  );

  function automatic st_t reset_state(input logic [31:0] rpc);
    st_t s;
    s.pc = rpc; s.inst = 32'h0; s.pc4 = 32'h0; s.v = 1'b0; s.fc = 32'h0;
    return s;
  endfunction

  // Reference behaviour of one clock edge (rst already low).
  function automatic st_t nxt(input st_t s, input logic st, input logic rd,
                              input logic [31:0] rp);
    st_t n = s;
    if (rd) begin
      n.pc = {rp[31:2], 2'b00}; n.inst = 32'h0; n.pc4 = 32'h0; n.v = 1'b0;
    end else if (!st) begin
      n.inst = 32'hA000_0000 | s.pc;
      n.pc4  = s.pc + 32'd4;
      n.v    = 1'b1;
      n.pc   = s.pc + 32'd4;
      n.fc   = s.fc + 32'd1;
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_inst(input int i, input string step, input st_t e);
    check($sformatf("%s.u%0d.imem_addr", step, i), i == 0 ? addr0 : addr1, e.pc);
    check($sformatf("%s.u%0d.current_inst", step, i), i == 0 ? inst0 : inst1, e.inst);
    check($sformatf("%s.u%0d.if_id_pc4", step, i), i == 0 ? pc4_0 : pc4_1, e.pc4);
    check($sformatf("%s.u%0d.if_id_valid", step, i), {31'h0, (i == 0 ? v0 : v1)}, {31'h0, e.v});
    check($sformatf("%s.u%0d.fetch_count", step, i), i == 0 ? fc0 : fc1, e.fc);
  endtask

  // One clock edge: push model prediction, drive inputs, pop and compare.
  task automatic step(input string name, input logic st, input logic rd,
                      input logic [31:0] rp);
    st_t e;
    for (int i = 0; i < 2; i++) begin
      m[i] = nxt(m[i], st, rd, rp);
      sb.push_back(m[i]);
    end
    stall = st; redirect = rd; redirect_pc = rp;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      if (sb.size() == 0) begin
        errors++;
        $error("FAIL %s scoreboard_empty observed=0 expected=1", name);
      end else begin
        e = sb.pop_front();
        check_inst(i, name, e);
      end
    end
  endtask

  initial begin
    m[0] = reset_state(32'h0000_0000);
    m[1] = reset_state(32'hFFFF_FFF8);

    // Reset held across edges.
    repeat (2) @(posedge clk);
    #1;
    check_inst(0, "reset", m[0]);
    check_inst(1, "reset", m[1]);
    rst = 1'b0;

    // Two fetches bring pc to 8 with A000_0004 in IF/ID.
    step("run0", 1'b0, 1'b0, 32'h0);
    step("run1", 1'b0, 1'b0, 32'h0);
    check("pre_stall.addr", addr0, 32'h8);
    check("pre_stall.inst", inst0, 32'hA000_0004);

    // Three stalled cycles freeze everything.
    for (int k = 0; k < 3; k++) step($sformatf("stall%0d", k), 1'b1, 1'b0, 32'h0);
    check("stall.addr", addr0, 32'h8);
    check("stall.inst", inst0, 32'hA000_0004);
    step("release", 1'b0, 1'b0, 32'h0);
    check("release.inst", inst0, 32'hA000_0008);
    check("release.fc", fc0, 32'd3);

    // Redirect at pc=C to unaligned 0x103: bubble, then target word.
    step("redir", 1'b0, 1'b1, 32'h0000_0103);
    check("redir.addr", addr0, 32'h100);
    check("redir.valid", {31'h0, v0}, 32'h0);
    step("redir_tgt", 1'b0, 1'b0, 32'h0);
    check("redir_tgt.inst", inst0, 32'hA000_0100);
    check("redir_tgt.pc4", pc4_0, 32'h104);
    step("run2", 1'b0, 1'b0, 32'h0);

    // Redirect during stall: redirect wins, count unchanged.
    step("redir_stall", 1'b1, 1'b1, 32'h0000_0040);
    check("redir_stall.addr", addr0, 32'h40);
    check("redir_stall.fc", fc0, 32'd5);
    step("stall_tgt", 1'b1, 1'b0, 32'h0);
    step("tgt", 1'b0, 1'b0, 32'h0);

    // Position at pc=0x20 with fetch_count=8.
    step("redir18", 1'b0, 1'b1, 32'h0000_0018);
    step("run3", 1'b0, 1'b0, 32'h0);
    step("run4", 1'b0, 1'b0, 32'h0);
    check("pre_arst.addr", addr0, 32'h20);
    check("pre_arst.fc", fc0, 32'd8);

    // Asynchronous reset between edges takes effect immediately.
    #3 rst = 1'b1;
    #1;
    m[0] = reset_state(32'h0000_0000);
    m[1] = reset_state(32'hFFFF_FFF8);
    check_inst(0, "arst", m[0]);
    check_inst(1, "arst", m[1]);
    @(posedge clk); #1;
    rst = 1'b0;

    // Straight-line restart and PC wrap on the second instance.
    step("sl0", 1'b0, 1'b0, 32'h0);
    check("wrap0.addr", addr1, 32'hFFFF_FFFC);
    step("sl1", 1'b0, 1'b0, 32'h0);
    check("wrap1.addr", addr1, 32'h0000_0000);
    check("wrap1.pc4", pc4_1, 32'h0000_0000);
    check("wrap1.inst", inst1, 32'hFFFF_FFFC);
    step("sl2", 1'b0, 1'b0, 32'h0);
    check("wrap2.addr", addr1, 32'h0000_0004);
    step("sl3", 1'b0, 1'b0, 32'h0);
    check("sl3.inst", inst0, 32'hA000_000C);
    check("sl3.pc4", pc4_0, 32'h10);
    check("sl3.fc", fc0, 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
